if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//   Instruction-fetch stage of the pipelined MIPS CPU; produces the cmd/PCPlusFourD stream the decode stage
//   consumes and applies decode's redirect (PCSrcD/PCBranchD). Issues word fetches to a variable-latency,
//   in-order instruction memory, buffers returned words in a small FIFO and drives the IF/ID pipeline register.
//   Outputs a NOP bubble (32'h0) whenever no valid instruction is available.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC fetched first after reset
//   BUF_DEPTH  2              fetch-buffer entries and max outstanding requests (legal 1..4)
// PORTS
//   clk          in   1   clock, all state on posedge
//   reset        in   1   synchronous, active-high
//   StallF       in   1   from hazard unit: issue no new fetch this cycle
//   StallD       in   1   from hazard unit: hold IF/ID register
//   PCSrcD       in   1   from decode: redirect fetch to PCBranchD
//   PCBranchD    in   32  redirect target
//   imem_req     out  1   fetch request valid (combinational)
//   imem_addr    out  32  fetch word address = pcF
//   imem_ack     in   1   memory accepts request this cycle (sampled only with imem_req)
//   imem_rvalid  in   1   response word valid; responses return in request order
//   imem_rdata   in   32  response word
//   cmdD         out  32  instruction to decode (32'h0 when bubble)
//   PCPlusFourD  out  32  address of cmdD + 4
//   validD       out  1   cmdD holds a real fetched instruction
// BEHAVIOUR
//   Reset (sync, high): pcF=RESET_PC, pc_resp=RESET_PC, buffer empty, outstanding=0, drop_cnt=0,
//     cmdD=0, PCPlusFourD=0, validD=0; imem_req=0 during reset. Memory shares reset; no pre-reset response arrives.
//   Issue: imem_req = !reset & !StallF & !PCSrcD & (count + outstanding < BUF_DEPTH); imem_addr = pcF.
//     Accept = imem_req & imem_ack -> pcF += 4, outstanding += 1. No address hold required across cycles.
//   Response (imem_rvalid): outstanding -= 1. If drop_cnt>0: discard word, drop_cnt -= 1.
//     Else push {imem_rdata, pc_resp} into buffer, pc_resp += 4. Reservation guarantees no overflow;
//     push when full is a protocol error (assertion).
//   IF/ID register, when !StallD and !PCSrcD: buffer non-empty -> cmdD=head.instr, PCPlusFourD=head.pc+4,
//     validD=1, pop; empty -> cmdD=0, validD=0, PCPlusFourD holds. StallD=1: all three hold, no pop.
//   No bypass: a word returned in cycle N is written to the buffer at the end of N, appears on cmdD from
//     cycle N+2 at the earliest. Same-cycle push and pop both take effect (count unchanged).
//   Redirect (PCSrcD=1, priority over StallD and StallF): pcF=pc_resp={PCBranchD[31:2],2'b00};
//     buffer cleared; cmdD=0, validD=0; drop_cnt = outstanding - (imem_rvalid ? 1 : 0), i.e. every in-flight
//     word is discarded; no request issued that cycle. First post-redirect fetch requested next cycle.
//   Redirect while drop_cnt>0 already: drop_cnt recomputed by the same rule (covers older and newer in-flight words).
//   Counters: pointers wrap mod BUF_DEPTH; count, outstanding, drop_cnt are $clog2(BUF_DEPTH+1) bits; PC adds wrap mod 2^32.
//   Invariants: count + outstanding <= BUF_DEPTH; drop_cnt <= outstanding.
// TESTING
//   1 Reset, ack=1, 1-cycle latency, words 0x20080005,0x20090003: cmdD shows them in order with
//     PCPlusFourD 4,8, validD=1; steady state sustains 1 instr/2 cycles (depth 2) with no gaps beyond that rate.
//   2 StallD=1 for 3 cycles with buffer full: cmdD/PCPlusFourD frozen, imem_req=0, no words lost;
//     release -> next two instrs in order.
//   3 PCSrcD=1, PCBranchD=0x40, one request in flight: that response discarded, next imem_addr=0x40,
//     cmdD=0/validD=0 next cycle, first valid cmdD has PCPlusFourD=0x44.
//   4 Redirect in same cycle as an arriving rvalid: that word dropped, drop_cnt=outstanding-1; no stale word reaches cmdD.
//   5 imem_ack=0 for 5 cycles: imem_req stays 1, addr stable, bubbles (cmdD=0) emitted, pcF not advanced.
//   6 reset asserted mid-stream with 2 buffered words: next cycle validD=0, cmdD=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues word fetches to an in-order, variable-latency instruction memory,
// buffers returned words and drives the IF/ID register, with decode-driven redirect and stale-word drop.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] cmdD,
  output logic [31:0] PCPlusFourD,
  output logic        validD
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CntW:0] DepthExt = (CntW + 1)'(BUF_DEPTH);
  localparam logic [CntW-1:0] DepthCnt = CntW'(BUF_DEPTH);

  logic [31:0]     pc_f_q, pc_f_d;
  logic [31:0]     pc_resp_q, pc_resp_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [31:0]     cmd_q, cmd_d;
  logic [31:0]     pcp4_q, pcp4_d;
  logic            valid_q, valid_d;

  logic [31:0] instr_q [BUF_DEPTH];
  logic [31:0] bpc_q   [BUF_DEPTH];

  logic        accept, push, pop;
  logic [31:0] redirect_pc;
  logic        unused_pcb;

  // Word alignment of the redirect target discards the low address bits.
  assign redirect_pc = {PCBranchD[31:2], 2'b00};
  assign unused_pcb  = ^PCBranchD[1:0];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(BUF_DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Slots are reserved at issue time so a returning word always has room.
  assign imem_req  = !reset && !StallF && !PCSrcD &&
                     (({1'b0, count_q} + {1'b0, outst_q}) < DepthExt);
  assign imem_addr = pc_f_q;
  assign accept    = imem_req && imem_ack;
  assign push      = imem_rvalid && !PCSrcD && (drop_q == '0);
  assign pop       = !PCSrcD && !StallD && (count_q != '0);

  always_comb begin
    pc_f_d    = pc_f_q;
    pc_resp_d = pc_resp_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    outst_d   = outst_q;
    drop_d    = drop_q;
    cmd_d     = cmd_q;
    pcp4_d    = pcp4_q;
    valid_d   = valid_q;

    if (PCSrcD) begin
      // Every word still in flight after this cycle belongs to the abandoned path.
      pc_f_d    = redirect_pc;
      pc_resp_d = redirect_pc;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      outst_d   = outst_q - CntW'(imem_rvalid);
      drop_d    = outst_q - CntW'(imem_rvalid);
      cmd_d     = '0;
      valid_d   = 1'b0;
    end else begin
      if (accept) begin
        pc_f_d = pc_f_q + 32'd4;
      end
      outst_d = outst_q + CntW'(accept) - CntW'(imem_rvalid);
      if (imem_rvalid && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
      end
      if (push) begin
        pc_resp_d = pc_resp_q + 32'd4;
        wr_ptr_d  = ptr_inc(wr_ptr_q);
      end
      if (!StallD) begin
        if (count_q != '0) begin
          cmd_d    = instr_q[rd_ptr_q];
          pcp4_d   = bpc_q[rd_ptr_q] + 32'd4;
          valid_d  = 1'b1;
          rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
          cmd_d   = '0;
          valid_d = 1'b0;
        end
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q    <= RESET_PC;
      pc_resp_q <= RESET_PC;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      outst_q   <= '0;
      drop_q    <= '0;
      cmd_q     <= '0;
      pcp4_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_f_q    <= pc_f_d;
      pc_resp_q <= pc_resp_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      cmd_q     <= cmd_d;
      pcp4_q    <= pcp4_d;
      valid_q   <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      instr_q[wr_ptr_q] <= imem_rdata;
      bpc_q[wr_ptr_q]   <= pc_resp_q;
    end
  end

  assign cmdD        = cmd_q;
  assign PCPlusFourD = pcp4_q;
  assign validD      = valid_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == DepthCnt)));

  a_rsp_expected: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && (outst_q == '0)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: in-order memory model with per-cycle response hold, a table of
// per-cycle expectations, and hand-written redirect/stall sequences.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, StallF, StallD, PCSrcD;
  logic [31:0] PCBranchD;
  logic        imem_req, imem_ack, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] cmdD, PCPlusFourD;
  logic        validD;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] pend [$];

  typedef struct {
    logic        rst, sd, br;
    logic [31:0] tgt;
    logic        ack, mh;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] caddr, pcp4;
  } vec_t;

  vec_t vecs [$];

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .StallD     (StallD),
    .PCSrcD     (PCSrcD),
    .PCBranchD  (PCBranchD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .cmdD       (cmdD),
    .PCPlusFourD(PCPlusFourD),
    .validD     (validD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_0003;
    return {8'hA5, a[23:0]};
  endfunction

  task automatic add(input logic rst, sd, br, input logic [31:0] tgt, input logic ack, mh,
                     input logic req, input logic [31:0] addr, input logic vld,
                     input logic [31:0] caddr, pcp4);
    vec_t v;
    v.rst = rst; v.sd = sd; v.br = br; v.tgt = tgt; v.ack = ack; v.mh = mh;
    v.req = req; v.addr = addr; v.vld = vld; v.caddr = caddr; v.pcp4 = pcp4;
    vecs.push_back(v);
  endtask

  // Inputs for one cycle; memory answers the oldest accepted request unless held.
  task automatic drive(input logic rst, sf, sd, br, input logic [31:0] tgt, input logic ack, mh);
    reset     = rst;
    StallF    = sf;
    StallD    = sd;
    PCSrcD    = br;
    PCBranchD = tgt;
    imem_ack  = ack;
    imem_rvalid = !rst && !mh && (pend.size() > 0);
    imem_rdata  = imem_rvalid ? word(pend[0]) : 32'hDEAD_BEEF;
    #1;
  endtask

  task automatic step();
    logic        acc, fire;
    logic [31:0] a, dummy;
    acc  = imem_req && imem_ack;
    a    = imem_addr;
    fire = imem_rvalid;
    @(posedge clk);
    @(negedge clk);
    if (reset) begin
      pend.delete();
    end else begin
      if (fire) dummy = pend.pop_front();
      if (acc) pend.push_back(a);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int vcnt;

    // rst sd br tgt ack mh | req addr | vld caddr pcp4
    add(1, 0, 0, 0,     1, 0, 0, 32'h00, 0, 0,     32'h00);
    add(0, 0, 0, 0,     1, 0, 1, 32'h00, 0, 0,     32'h00);
    add(0, 0, 0, 0,     1, 0, 1, 32'h04, 0, 0,     32'h00);
    add(0, 0, 0, 0,     1, 0, 0, 32'h08, 0, 0,     32'h00);
    add(0, 0, 0, 0,     1, 0, 1, 32'h08, 1, 32'h00, 32'h04);
    add(0, 0, 0, 0,     1, 0, 1, 32'h0C, 1, 32'h04, 32'h08);
    add(0, 0, 0, 0,     1, 0, 0, 32'h10, 0, 0,     32'h08);
    add(0, 0, 0, 0,     1, 0, 1, 32'h10, 1, 32'h08, 32'h0C);
    add(0, 0, 0, 0,     1, 0, 1, 32'h14, 1, 32'h0C, 32'h10);
    add(0, 0, 0, 0,     1, 0, 0, 32'h18, 0, 0,     32'h10);
    // decode stall while the buffer fills
    add(0, 1, 0, 0,     1, 0, 1, 32'h18, 1, 32'h10, 32'h14);
    add(0, 1, 0, 0,     1, 0, 0, 32'h1C, 1, 32'h10, 32'h14);
    add(0, 1, 0, 0,     1, 0, 0, 32'h1C, 1, 32'h10, 32'h14);
    add(0, 1, 0, 0,     1, 0, 0, 32'h1C, 1, 32'h10, 32'h14);
    add(0, 0, 0, 0,     1, 0, 0, 32'h1C, 1, 32'h10, 32'h14);
    add(0, 0, 0, 0,     1, 0, 1, 32'h1C, 1, 32'h14, 32'h18);
    add(0, 0, 0, 0,     1, 0, 1, 32'h20, 1, 32'h18, 32'h1C);
    // redirect with one word in flight
    add(0, 0, 0, 0,     1, 1, 0, 32'h24, 0, 0,     32'h1C);
    add(0, 0, 1, 32'h40, 1, 1, 0, 32'h24, 1, 32'h1C, 32'h20);
    add(0, 0, 0, 0,     1, 0, 1, 32'h40, 0, 0,     32'h20);
    add(0, 0, 0, 0,     1, 0, 1, 32'h44, 0, 0,     32'h20);
    add(0, 0, 0, 0,     1, 0, 0, 32'h48, 0, 0,     32'h20);
    add(0, 0, 0, 0,     1, 0, 1, 32'h48, 1, 32'h40, 32'h44);
    // two in flight, redirect as the first one returns
    add(0, 0, 0, 0,     1, 1, 1, 32'h4C, 1, 32'h44, 32'h48);
    add(0, 0, 1, 32'h80, 1, 0, 0, 32'h50, 0, 0,     32'h48);
    add(0, 0, 0, 0,     1, 0, 1, 32'h80, 0, 0,     32'h48);
    add(0, 0, 0, 0,     1, 0, 1, 32'h84, 0, 0,     32'h48);
    add(0, 0, 0, 0,     1, 0, 0, 32'h88, 0, 0,     32'h48);
    add(0, 0, 0, 0,     1, 0, 1, 32'h88, 1, 32'h80, 32'h84);
    // memory refuses requests for five cycles
    add(0, 0, 0, 0,     0, 0, 1, 32'h8C, 1, 32'h84, 32'h88);
    add(0, 0, 0, 0,     0, 0, 1, 32'h8C, 0, 0,     32'h88);
    add(0, 0, 0, 0,     0, 0, 1, 32'h8C, 1, 32'h88, 32'h8C);
    add(0, 0, 0, 0,     0, 0, 1, 32'h8C, 0, 0,     32'h8C);
    add(0, 0, 0, 0,     0, 0, 1, 32'h8C, 0, 0,     32'h8C);
    add(0, 0, 0, 0,     1, 0, 1, 32'h8C, 0, 0,     32'h8C);
    add(0, 0, 0, 0,     1, 0, 1, 32'h90, 0, 0,     32'h8C);
    add(0, 0, 0, 0,     1, 0, 0, 32'h94, 0, 0,     32'h8C);
    add(0, 0, 0, 0,     1, 0, 1, 32'h94, 1, 32'h8C, 32'h90);
    // fill the buffer with two words, then reset mid-stream
    add(0, 1, 0, 0,     1, 0, 1, 32'h98, 1, 32'h90, 32'h94);
    add(0, 1, 0, 0,     1, 0, 0, 32'h9C, 1, 32'h90, 32'h94);
    add(1, 0, 0, 0,     1, 0, 0, 32'h9C, 1, 32'h90, 32'h94);
    add(0, 0, 0, 0,     1, 0, 1, 32'h00, 0, 0,     32'h00);
    add(0, 0, 0, 0,     1, 0, 1, 32'h04, 0, 0,     32'h00);
    add(0, 0, 0, 0,     1, 0, 0, 32'h08, 0, 0,     32'h00);
    add(0, 0, 0, 0,     1, 0, 1, 32'h08, 1, 32'h00, 32'h04);

    drive(1, 0, 0, 0, 0, 1, 0);
    step();
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, 1'b0, vecs[i].sd, vecs[i].br, vecs[i].tgt, vecs[i].ack, vecs[i].mh);
      chk($sformatf("row%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
      chk($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("row%0d validD", i), {31'b0, validD}, {31'b0, vecs[i].vld});
      chk($sformatf("row%0d cmdD", i), cmdD, vecs[i].vld ? word(vecs[i].caddr) : 32'h0);
      chk($sformatf("row%0d PCPlusFourD", i), PCPlusFourD, vecs[i].pcp4);
      step();
    end

    // Back-to-back redirects while older words are still being dropped; unaligned target.
    drive(1, 0, 0, 0, 0, 1, 0);
    step();
    step();
    drive(0, 0, 0, 0, 0, 1, 1);
    chk("dbl addr0", imem_addr, 32'h0);
    step();
    drive(0, 0, 0, 0, 0, 1, 1);
    chk("dbl addr1", imem_addr, 32'h4);
    chk("dbl req1", {31'b0, imem_req}, 32'h1);
    step();
    drive(0, 0, 0, 1, 32'h100, 1, 1);
    chk("dbl req redirect1", {31'b0, imem_req}, 32'h0);
    step();
    drive(0, 0, 0, 1, 32'h202, 1, 0);
    chk("dbl req redirect2", {31'b0, imem_req}, 32'h0);
    step();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("dbl target addr", imem_addr, 32'h200);
    chk("dbl req after", {31'b0, imem_req}, 32'h1);
    chk("dbl valid d4", {31'b0, validD}, 32'h0);
    step();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("dbl valid d5", {31'b0, validD}, 32'h0);
    step();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("dbl valid d6", {31'b0, validD}, 32'h0);
    step();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("dbl first cmd", cmdD, word(32'h200));
    chk("dbl first pc4", PCPlusFourD, 32'h204);
    chk("dbl first valid", {31'b0, validD}, 32'h1);
    step();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("dbl second cmd", cmdD, word(32'h204));
    chk("dbl second pc4", PCPlusFourD, 32'h208);
    step();

    // Sustained rate with single-cycle memory: at least one instruction per two cycles.
    vcnt = 0;
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      if (validD) vcnt++;
      step();
    end
    chk("rate >= 1/2", {31'b0, vcnt >= 6}, 32'h1);

    // StallF blocks issue even once the buffer has drained.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 0, 1, 0);
      chk($sformatf("stallf req%0d", k), {31'b0, imem_req}, 32'h0);
      step();
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("stallf release req", {31'b0, imem_req}, 32'h1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
